// File: rtl/memory_access_arbiter_if.sv
// Bundles the fetch, data and memory handshake channels that meet at the memory access arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface memory_access_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  instruction_request;
    logic [DATA_WIDTH-1:0] instruction_address;
    logic                  instruction_address_ok;
    logic                  instruction_data_ok;
    logic [DATA_WIDTH-1:0] instruction_read_data;

    logic                  data_request;
    logic                  data_write;
    logic [3:0]            data_byte_enable;
    logic [DATA_WIDTH-1:0] data_address;
    logic [DATA_WIDTH-1:0] data_write_data;
    logic                  data_address_ok;
    logic                  data_data_ok;
    logic [DATA_WIDTH-1:0] data_read_data;

    logic                  memory_request;
    logic                  memory_write;
    logic [3:0]            memory_byte_enable;
    logic [DATA_WIDTH-1:0] memory_address;
    logic [DATA_WIDTH-1:0] memory_write_data;
    logic                  memory_address_ok;
    logic                  memory_data_ok;
    logic [DATA_WIDTH-1:0] memory_read_data;

    modport slave (
        input  instruction_request, instruction_address,
        output instruction_address_ok, instruction_data_ok, instruction_read_data,
        input  data_request, data_write, data_byte_enable, data_address, data_write_data,
        output data_address_ok, data_data_ok, data_read_data,
        output memory_request, memory_write, memory_byte_enable, memory_address, memory_write_data,
        input  memory_address_ok, memory_data_ok, memory_read_data
    );

    modport master (
        output instruction_request, instruction_address,
        input  instruction_address_ok, instruction_data_ok, instruction_read_data,
        output data_request, data_write, data_byte_enable, data_address, data_write_data,
        input  data_address_ok, data_data_ok, data_read_data,
        input  memory_request, memory_write, memory_byte_enable, memory_address, memory_write_data,
        output memory_address_ok, memory_data_ok, memory_read_data
    );
endinterface

// File: rtl/memory_access_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, one transaction at a time.
// Data wins ties unless it has already won DATA_STREAK_LIMIT times in a row while a fetch was waiting.
module memory_access_arbiter #(
    parameter int DATA_WIDTH        = 32,
    parameter int DATA_STREAK_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    memory_access_arbiter_if.slave  bus
);
    localparam int STREAK_WIDTH = $clog2(DATA_STREAK_LIMIT + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(DATA_STREAK_LIMIT);
    localparam logic [DATA_WIDTH-1:0]   ZERO_WORD  = '0;

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA} state_t;
    typedef enum logic {OWNER_INSTRUCTION, OWNER_DATA} owner_t;

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic [STREAK_WIDTH-1:0] data_streak_q, data_streak_d;
    logic                    data_wins;
    logic                    owner_is_data;

    assign owner_is_data = (owner_q == OWNER_DATA);
    assign data_wins = bus.data_request &&
                       (!bus.instruction_request || (data_streak_q != STREAK_MAX));

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        data_streak_d = data_streak_q;
        case (state_q)
            IDLE: begin
                if (bus.instruction_request || bus.data_request) begin
                    state_d = REQUEST;
                    if (data_wins) begin
                        owner_d = OWNER_DATA;
                        if (!bus.instruction_request) begin
                            data_streak_d = '0;
                        end else if (data_streak_q != STREAK_MAX) begin
                            data_streak_d = data_streak_q + 1'b1;
                        end
                    end else begin
                        owner_d       = OWNER_INSTRUCTION;
                        data_streak_d = '0;
                    end
                end
            end
            REQUEST: begin
                if (bus.memory_address_ok) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.memory_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_INSTRUCTION;
            data_streak_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            data_streak_q <= data_streak_d;
        end
    end

    // Handshake pulses and the memory-side mux must be combinational so the owner sees them in the same cycle.
    always_comb begin
        bus.memory_request         = 1'b0;
        bus.memory_write           = 1'b0;
        bus.memory_byte_enable     = 4'b0000;
        bus.memory_address         = ZERO_WORD;
        bus.memory_write_data      = ZERO_WORD;
        bus.instruction_address_ok = 1'b0;
        bus.instruction_data_ok    = 1'b0;
        bus.instruction_read_data  = ZERO_WORD;
        bus.data_address_ok        = 1'b0;
        bus.data_data_ok           = 1'b0;
        bus.data_read_data         = ZERO_WORD;
        case (state_q)
            REQUEST: begin
                bus.memory_request = 1'b1;
                if (owner_is_data) begin
                    bus.memory_write       = bus.data_write;
                    bus.memory_byte_enable = bus.data_byte_enable;
                    bus.memory_address     = bus.data_address;
                    bus.memory_write_data  = bus.data_write_data;
                    bus.data_address_ok    = bus.memory_address_ok;
                end else begin
                    bus.memory_address         = bus.instruction_address;
                    bus.instruction_address_ok = bus.memory_address_ok;
                end
            end
            WAIT_DATA: begin
                if (bus.memory_data_ok) begin
                    if (owner_is_data) begin
                        bus.data_data_ok   = 1'b1;
                        bus.data_read_data = bus.memory_read_data;
                    end else begin
                        bus.instruction_data_ok   = 1'b1;
                        bus.instruction_read_data = bus.memory_read_data;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
- Shares the core's single SRAM-like memory port between the IF-stage instruction fetch and the IO-stage data access.
- One transaction is outstanding at a time. A split address/data handshake runs on every side.
- Data wins by default; a bounded-streak rule stops instruction fetch from starving.
- Sits between the pipeline stages and the memory/bridge interface in the CPU core.

Parameters:
DATA_WIDTH, 32, data and address width; equals CPU_DATA_WIDTH
DATA_STREAK_LIMIT, 4, max consecutive data grants while a fetch is pending (>=1)

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
instruction_request  in  1  fetch request, held until instruction_address_ok
instruction_address  in  DATA_WIDTH  fetch address
instruction_address_ok  out  1  fetch address accepted (1-cycle pulse)
instruction_data_ok  out  1  fetch data valid (1-cycle pulse)
instruction_read_data  out  DATA_WIDTH  fetched word
data_request  in  1  data request, held until data_address_ok
data_write  in  1  1 = store, 0 = load
data_byte_enable  in  4  store byte lanes
data_address  in  DATA_WIDTH  data address
data_write_data  in  DATA_WIDTH  store data
data_address_ok  out  1  data address accepted (pulse)
data_data_ok  out  1  load data / store completion (pulse)
data_read_data  out  DATA_WIDTH  load word
memory_request  out  1  request to memory
memory_write  out  1  write flag
memory_byte_enable  out  4  byte lanes
memory_address  out  DATA_WIDTH  address
memory_write_data  out  DATA_WIDTH  store data
memory_address_ok  in  1  memory accepted address
memory_data_ok  in  1  memory response valid
memory_read_data  in  DATA_WIDTH  response data

Behaviour:
- Reset is async on reset_n low. It forces state IDLE, owner = INSTRUCTION, and data_streak = 0.
- Every output is 0 while in reset and in IDLE.
- The FSM states are IDLE, REQUEST and WAIT_DATA. The owner is a register that is written only in IDLE.
- IDLE, no request pending: stay in IDLE.
- IDLE, any request pending: arbitrate, register the owner, and go to REQUEST next cycle. This gives 1 cycle of arbitration latency.
- Arbitration rules:
  - Only one requester asserted: that requester wins.
  - Both asserted: data wins, unless data_streak == DATA_STREAK_LIMIT; then instruction wins.
- Streak update, applied at arbitration:
  - Data grant with instruction_request high: data_streak + 1, saturating at the limit.
  - Instruction grant, or data grant with no fetch pending: data_streak = 0.
- REQUEST:
  - memory_request = 1. Address, write, byte_enable and write_data are combinationally muxed from the owner's inputs.
  - For an instruction owner: memory_write = 0, byte_enable = 4'b0000, write_data = 0.
  - The owner is locked for the whole REQUEST state, even if the other requester asserts.
  - On memory_address_ok, pulse the owner's *_address_ok in the same cycle (combinational) and go to WAIT_DATA.
- WAIT_DATA:
  - memory_request = 0.
  - On memory_data_ok, pulse the owner's *_data_ok in the same cycle. The owner's *_read_data = memory_read_data.
  - Then return to IDLE. New requests are arbitrated there, so there is 1 idle bubble between transactions.
- Non-owner *_read_data is 0. Owner *_read_data is 0 whenever memory_data_ok is low.
- memory_data_ok in IDLE or REQUEST is a protocol violation. It is ignored and flagged by a bench assertion.
- Reset mid-transaction: return to IDLE immediately. A late memory_data_ok for the abandoned transaction then arrives in IDLE and is dropped.
- The requester may drop its request before address_ok only through reset. Requests must otherwise stay stable.

Test Plan:
- Fetch only: instruction_request=1, address 0xBFC00000; memory_address_ok in cycle 2, memory_data_ok in cycle 4 with 0x3C1D0001 -> memory_request high in cycles 1-2; instruction_address_ok pulses in cycle 2; instruction_data_ok pulses in cycle 4 with 0x3C1D0001; data_* outputs stay 0.
- Store: data_request=1, data_write=1, byte_enable 4'b0011, address 0x80001000, write_data 0x0000BEEF -> memory_write=1, byte_enable 0011, memory_address 0x80001000 and write_data passed through; data_data_ok on the response; instruction_* stay 0.
- Simultaneous requests, both held, single-cycle memory -> order D,D,D,D,I,D,D,D,D,I with DATA_STREAK_LIMIT=4; data_streak returns to 0 after each I grant.
- Owner lock: instruction owns REQUEST; data_request rises while memory_address_ok is withheld for 3 cycles -> memory_address stays the fetch address; data is granted only after the fetch's data_ok plus the IDLE cycle.
- Reset in WAIT_DATA: assert reset_n=0 for 1 cycle, then memory_data_ok arrives -> no *_data_ok pulse; all outputs 0; the next request is arbitrated normally with data_streak = 0.
- Spurious memory_data_ok in IDLE -> ignored; the assertion fires; state stays IDLE.
